// File: rtl/apple1_kbd_pkg.sv
// Shared types, scancode/ASCII constants and the set-2 scancode to Apple-1 ASCII table
// for the PS/2 keyboard front end.
package apple1_kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F12    = 8'h07;

    localparam logic [6:0] ASCII_CR     = 7'h0D;
    localparam logic [6:0] ASCII_RUBOUT = 7'h5F;
    localparam logic [6:0] ASCII_ESC    = 7'h1B;

    // Returns 0 for anything without a printable or control mapping.
    function automatic logic [6:0] sc_to_ascii(input logic [7:0] code, input logic shift);
        logic [6:0] w_ascii;
        case (code)
            8'h1C: w_ascii = 7'h41;
            8'h32: w_ascii = 7'h42;
            8'h21: w_ascii = 7'h43;
            8'h23: w_ascii = 7'h44;
            8'h24: w_ascii = 7'h45;
            8'h2B: w_ascii = 7'h46;
            8'h34: w_ascii = 7'h47;
            8'h33: w_ascii = 7'h48;
            8'h43: w_ascii = 7'h49;
            8'h3B: w_ascii = 7'h4A;
            8'h42: w_ascii = 7'h4B;
            8'h4B: w_ascii = 7'h4C;
            8'h3A: w_ascii = 7'h4D;
            8'h31: w_ascii = 7'h4E;
            8'h44: w_ascii = 7'h4F;
            8'h4D: w_ascii = 7'h50;
            8'h15: w_ascii = 7'h51;
            8'h2D: w_ascii = 7'h52;
            8'h1B: w_ascii = 7'h53;
            8'h2C: w_ascii = 7'h54;
            8'h3C: w_ascii = 7'h55;
            8'h2A: w_ascii = 7'h56;
            8'h1D: w_ascii = 7'h57;
            8'h22: w_ascii = 7'h58;
            8'h35: w_ascii = 7'h59;
            8'h1A: w_ascii = 7'h5A;
            8'h45: w_ascii = shift ? 7'h29 : 7'h30;
            8'h16: w_ascii = shift ? 7'h21 : 7'h31;
            8'h1E: w_ascii = shift ? 7'h40 : 7'h32;
            8'h26: w_ascii = shift ? 7'h23 : 7'h33;
            8'h25: w_ascii = shift ? 7'h24 : 7'h34;
            8'h2E: w_ascii = shift ? 7'h25 : 7'h35;
            8'h36: w_ascii = shift ? 7'h5E : 7'h36;
            8'h3D: w_ascii = shift ? 7'h26 : 7'h37;
            8'h3E: w_ascii = shift ? 7'h2A : 7'h38;
            8'h46: w_ascii = shift ? 7'h28 : 7'h39;
            8'h0E: w_ascii = shift ? 7'h7E : 7'h60;
            8'h4E: w_ascii = shift ? 7'h5F : 7'h2D;
            8'h55: w_ascii = shift ? 7'h2B : 7'h3D;
            8'h54: w_ascii = shift ? 7'h7B : 7'h5B;
            8'h5B: w_ascii = shift ? 7'h7D : 7'h5D;
            8'h5D: w_ascii = shift ? 7'h7C : 7'h5C;
            8'h4C: w_ascii = shift ? 7'h3A : 7'h3B;
            8'h52: w_ascii = shift ? 7'h22 : 7'h27;
            8'h41: w_ascii = shift ? 7'h3C : 7'h2C;
            8'h49: w_ascii = shift ? 7'h3E : 7'h2E;
            8'h4A: w_ascii = shift ? 7'h3F : 7'h2F;
            8'h29: w_ascii = 7'h20;
            SC_ENTER: w_ascii = ASCII_CR;
            SC_BKSP:  w_ascii = ASCII_RUBOUT;
            SC_ESC:   w_ascii = ASCII_ESC;
            default:  w_ascii = 7'h00;
        endcase
        return w_ascii;
    endfunction

    function automatic logic is_letter(input logic [6:0] ascii);
        return (ascii >= 7'h41) && (ascii <= 7'h5A);
    endfunction

endpackage

// File: rtl/apple1_ps2_kbd_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, frame FSM with
// odd-parity/stop checking and an inactivity timeout for abandoned frames.
module ps2_rx
    import apple1_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 14318
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_din,
    output logic [7:0] o_code,
    output logic       o_code_valid,
    output logic       o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_din_sync;
    logic [FW-1:0] r_filt_cnt;
    logic          r_filt_clk;
    logic          r_filt_clk_d;
    logic          r_fall;
    logic          r_bit;

    rx_state_t     r_state, w_state_next;
    logic [2:0]    r_bit_cnt, w_bit_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_parity, w_parity_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic [7:0]    r_code, w_code_next;
    logic          r_code_valid, w_code_valid_next;
    logic          r_frame_err, w_frame_err_next;

    // The data bit is captured on the same edge the filtered-clock fall is registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_sync   <= 2'b11;
            r_din_sync   <= 2'b11;
            r_filt_cnt   <= '0;
            r_filt_clk   <= 1'b1;
            r_filt_clk_d <= 1'b1;
            r_fall       <= 1'b0;
            r_bit        <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_din_sync <= {r_din_sync[0], i_ps2_din};
            if (r_clk_sync[1] == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
            r_filt_clk_d <= r_filt_clk;
            r_fall       <= r_filt_clk_d & ~r_filt_clk;
            r_bit        <= r_din_sync[1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_timer      <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_parity     <= w_parity_next;
            r_timer      <= w_timer_next;
            r_code       <= w_code_next;
            r_code_valid <= w_code_valid_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_parity_next     = r_parity;
        w_code_next       = r_code;
        w_code_valid_next = 1'b0;
        w_frame_err_next  = 1'b0;
        w_timer_next      = (r_state == RX_IDLE || r_fall) ? '0 : r_timer + 1'b1;

        case (r_state)
            RX_IDLE: begin
                if (r_fall && !r_bit) begin
                    w_state_next   = RX_DATA;
                    w_bit_cnt_next = '0;
                end
            end
            RX_DATA: begin
                if (r_fall) begin
                    w_shift_next = {r_bit, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = RX_PARITY;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (r_fall) begin
                    w_parity_next = r_bit;
                    w_state_next  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_fall) begin
                    w_state_next   = RX_IDLE;
                    w_bit_cnt_next = '0;
                    if (r_bit && (^{r_shift, r_parity})) begin
                        w_code_next       = r_shift;
                        w_code_valid_next = 1'b1;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase

        // A stalled partial frame is dropped so the next start bit realigns cleanly.
        if (r_state != RX_IDLE && !r_fall && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_next   = RX_IDLE;
            w_bit_cnt_next = '0;
            w_timer_next   = '0;
        end
    end

    assign o_code       = r_code;
    assign o_code_valid = r_code_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/apple1_ps2_kbd.sv
// Apple-1 keyboard front end: PS/2 receiver plus make/break/modifier decoding,
// ASCII translation, ready/ack handshake and clear-screen/reset request pulses.
module apple1_ps2_kbd
    import apple1_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 14318
) (
    input  logic       i_clk14,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_din,
    output logic [6:0] o_kbd_data,
    output logic       o_kbd_ready,
    input  logic       i_kbd_ack,
    output logic       o_cls_req,
    output logic       o_reset_req
);

    logic [7:0] w_code;
    logic       w_code_valid;
    logic       w_frame_err_unused;

    logic       r_brk;
    logic       r_ext;
    logic       r_shift;
    logic       r_ctrl;
    logic [6:0] r_kbd_data;
    logic       r_kbd_ready;
    logic       r_cls_req;
    logic       r_reset_req;

    logic       w_key_event;
    logic       w_make;
    logic       w_is_shift;
    logic       w_is_ctrl;
    logic [6:0] w_lookup;
    logic [6:0] w_char;
    logic       w_char_valid;
    logic       w_cls;
    logic       w_rst;

    // Corrupt frames are simply dropped; the error strobe is left as a diagnostic hook.
    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk        (i_clk14),
        .i_rst_n      (i_rst_n),
        .i_ps2_clk    (i_ps2_clk),
        .i_ps2_din    (i_ps2_din),
        .o_code       (w_code),
        .o_code_valid (w_code_valid),
        .o_frame_err  (w_frame_err_unused)
    );

    always_comb begin
        w_key_event  = w_code_valid && (w_code != SC_BREAK) && (w_code != SC_EXT);
        w_make       = w_key_event && !r_brk;
        w_is_shift   = !r_ext && ((w_code == SC_LSHIFT) || (w_code == SC_RSHIFT));
        w_is_ctrl    = (w_code == SC_CTRL);
        w_lookup     = r_ext ? ((w_code == SC_ENTER) ? ASCII_CR : 7'h00)
                             : sc_to_ascii(w_code, r_shift);
        w_char       = (r_ctrl && is_letter(w_lookup)) ? (w_lookup & 7'h1F) : w_lookup;
        w_char_valid = w_make && !w_is_shift && !w_is_ctrl && (w_lookup != 7'h00);
        w_cls        = w_make && !r_ext && (w_code == SC_F1);
        w_rst        = w_make && !r_ext && (w_code == SC_F12);
    end

    // A freshly loaded character takes priority over a coincident acknowledge.
    always_ff @(posedge i_clk14) begin
        if (!i_rst_n) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_shift     <= 1'b0;
            r_ctrl      <= 1'b0;
            r_kbd_data  <= '0;
            r_kbd_ready <= 1'b0;
            r_cls_req   <= 1'b0;
            r_reset_req <= 1'b0;
        end else begin
            r_cls_req   <= w_cls;
            r_reset_req <= w_rst;
            if (i_kbd_ack && r_kbd_ready) begin
                r_kbd_ready <= 1'b0;
            end
            if (w_char_valid) begin
                r_kbd_data  <= w_char;
                r_kbd_ready <= 1'b1;
            end
            if (w_code_valid) begin
                if (w_code == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_code == SC_EXT) begin
                    r_ext <= 1'b1;
                end else begin
                    if (w_is_shift) begin
                        r_shift <= !r_brk;
                    end
                    if (w_is_ctrl) begin
                        r_ctrl <= !r_brk;
                    end
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
        end
    end

    assign o_kbd_data  = r_kbd_data;
    assign o_kbd_ready = r_kbd_ready;
    assign o_cls_req   = r_cls_req;
    assign o_reset_req = r_reset_req;

endmodule

// File: doc/apple1_ps2_kbd.md
# apple1_ps2_kbd

PS/2 keyboard front end for the Apple-1 core. It sits between user_io's `ps2_kbd_clk`/`ps2_kbd_data` outputs and the Apple-1 keyboard PIA port. The block receives PS/2 frames and tracks make/break and modifier state. It translates scancodes into the Apple-1's 7-bit upper-case ASCII and presents each character with a ready/ack handshake. It also decodes dedicated keys into clear-screen and reset request pulses.

## Interface
- `FILTER_LEN`, default 8: clk14 cycles the synchronized PS/2 clock must hold a level before the filtered clock changes.
- `TIMEOUT_CYCLES`, default 14318: clk14 cycles (≈1 ms) without a filtered falling edge before a partial frame is abandoned.
- `clk14`  in  1  system clock, 14.31818 MHz; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ps2_clk`  in  1  PS/2 clock from user_io (asynchronous).
- `ps2_din`  in  1  PS/2 data from user_io (asynchronous).
- `kbd_data`  out  7  ASCII code of the last key.
- `kbd_ready`  out  1  character available; held until acknowledged.
- `kbd_ack`  in  1  one-cycle pulse when the PIA reads the keyboard register.
- `cls_req`  out  1  one-cycle pulse on F1 make.
- `reset_req`  out  1  one-cycle pulse on F12 make.

## Operation
- Input conditioning: 2-FF synchronizers on both inputs. The filtered clock takes the synchronized level only after FILTER_LEN consecutive equal samples. A falling edge of the filtered clock samples the synchronized data.
- Frame receiver states: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - In IDLE, a falling edge with data 0 enters DATA. Data 1 in IDLE is ignored.
  - Parity must be odd and the stop bit must be 1. On failure, discard the byte and return to IDLE. No output.
  - Any non-IDLE state with no falling edge for TIMEOUT_CYCLES returns to IDLE, discarding the partial frame.
- Decoder, per valid byte:
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - Any other byte is a key event that clears both `brk` and `ext` afterwards.
- Modifiers: 0x12/0x59 (shift) and 0x14 (ctrl; also E0 14) are set on make and cleared on break. They produce no character.
- Break events produce no output.
- Make events produce output as follows:
  - Letters: upper case regardless of shift. With ctrl held, the output is the code AND 0x1F.
  - Digits and punctuation: US layout, with the shifted variant while shift is held. Space maps to 0x20.
  - Enter 0x5A (also E0 5A) → 0x0D. Backspace 0x66 → 0x5F. Esc 0x76 → 0x1B.
  - F1 (0x05) → `cls_req`. F12 (0x07) → `reset_req`. Neither produces a character.
  - Unmapped or other extended codes are ignored.
- Handshake:
  - A new character loads `kbd_data` and sets `kbd_ready`.
  - `kbd_ack` while ready clears `kbd_ready` on the next edge. `kbd_ack` while not ready has no effect.
  - A new character while ready overwrites `kbd_data`; `kbd_ready` stays 1.
  - A new character coincident with `kbd_ack`: the new character wins and `kbd_ready` stays 1.
- Reset: receiver returns to IDLE with the bit counter at 0. Filter and synchronizers preset to 1. `brk`, `ext`, shift and ctrl clear.

## Timing
- Reset values: `kbd_data`=0x00, `kbd_ready`=0, `cls_req`=0, `reset_req`=0.
- Reset asserted mid-frame or mid-handshake: all state returns to reset values on the first edge with `rst_n`=0. A partially received frame is lost.
- Raw `ps2_clk` fall → internal sample edge: 2 sync + FILTER_LEN + 1 edge detect = FILTER_LEN+3 cycles.
- Stop-bit sample → scancode valid strobe: 1 cycle.
- Scancode valid → `kbd_ready`/`kbd_data` or a pulse output: 1 cycle (registered lookup).
- Total from the stop-bit raw fall: FILTER_LEN+5 cycles (13 at default).
- `cls_req`/`reset_req` are exactly one clk14 cycle wide.
- Nominal 10–16.7 kHz PS/2 clock gives ≥400 clk14 cycles per half period, so FILTER_LEN=8 never masks valid edges.

## Structure
- Package `apple1_kbd_pkg`:
  - receiver state enum;
  - scancode constants (SC_BREAK, SC_EXT, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ENTER, SC_BKSP, SC_ESC, SC_F1, SC_F12);
  - ASCII constants (CR, RUBOUT=0x5F, ESC);
  - the scancode→ASCII function, unshifted and shifted.
- Sub-module `ps2_rx` (synchronizer, filter, frame FSM, timeout). Outputs: `code[7:0]`, `code_valid` pulse, `frame_err` pulse.
- The decoder and handshake stay in the top module.

## Test plan
- Send 0x1C with good parity → after 13 cycles `kbd_data`=0x41 and `kbd_ready`=1. Pulse `kbd_ack` → `kbd_ready`=0 next cycle.
- Send 12, 16, F0 16, F0 12 → one character, 0x21 ('!'). Breaks produce nothing and shift is cleared afterwards.
- Send 0x1C with even parity, then a frame with stop bit 0 → no `kbd_ready`. A following good 0x32 frame → 0x42.
- Send 5 bits, idle 15000 cycles, then a full 0x5A frame → `kbd_data`=0x0D. The stale partial frame is discarded.
- Send 0x05 → `cls_req` high for exactly 1 cycle. Send 0x07 → `reset_req` for 1 cycle. `kbd_ready` stays 0 throughout.
- Send 0x1C with ready still set and `kbd_ack` asserted on the cycle the new character loads → `kbd_ready` remains 1 with the new data. Assert `rst_n`=0 mid-frame → all outputs 0 on the next edge.
